simmem_wbeat_tracker: RTL
=========================

Name: simmem_wbeat_tracker

Overview:
Sits directly downstream of the AXI write address/data channel split in simmem, and upstream of the write-response bank and delay calculator. Queues accepted write-address bursts (length field plus internal identifier) and counts W beats against each burst's effective length. When a burst's last beat is consumed, it emits one completion token per burst carrying the internal identifier and a protocol-error flag. The write-response bank uses this token to release the response.

Parameters:
Depth, 3 (= WRspBankCapa), number of outstanding bursts the address queue holds; any value >= 1, not required to be a power of 2
IidW, WRspBankAddrW, width of internal identifier (write_iid_t)
MaxLenField, 3 (= MaxBurstLenField), largest legal AxLen value
CntW, XBurstEffLenW, width of beat counter (holds 0..MaxLenField+1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
waddr_valid_i  in  1  write address burst offered
waddr_ready_o  out  1  address queue can accept
waddr_len_i  in  AxLenWidth(8)  AxLen field of offered burst
waddr_iid_i  in  IidW  internal identifier allocated by the response bank
wdata_valid_i  in  1  W beat offered
wdata_ready_o  out  1  W beat accepted this cycle
wdata_last_i  in  1  WLAST of offered beat
done_valid_o  out  1  burst-completion token valid
done_ready_i  in  1  consumer takes token
done_iid_o  out  IidW  iid of completed burst
done_err_o  out  1  burst had a protocol error
occupancy_o  out  $clog2(Depth+1)  number of queued bursts, including the one in progress

Behaviour:
- Reset: rst_i high at a rising edge clears all state. Queue pointers, occupancy and beat counter go to 0; done register goes invalid.
- Reset output values, visible in the cycle after the reset edge and held while rst_i is high: waddr_ready_o=0, wdata_ready_o=0, done_valid_o=0, done_iid_o=0, done_err_o=0, occupancy_o=0.
- Reset mid-operation discards queued bursts and any pending token without emitting them.
- Address queue: circular FIFO of Depth entries, each {len_clip, len_err, iid}.
  - Pointers wrap from Depth-1 to 0; there is no power-of-2 assumption.
  - waddr_ready_o = !rst_i && (occupancy < Depth).
  - Push on waddr_valid_i && waddr_ready_o.
  - len_err = (waddr_len_i > MaxLenField). len_clip = len_err ? MaxLenField : waddr_len_i.
- Head entry and beat limit:
  - The head entry is the burst in progress.
  - Effective length E = len_clip + 1, computed in CntW bits.
  - beat_cnt counts accepted beats of the head burst and starts at 0.
- W acceptance:
  - wdata_ready_o = !rst_i && (occupancy > 0) && (!done_valid_o || done_ready_i).
  - W beats are never accepted before their address; there is no write-data-before-address support.
  - A beat pushed to the queue at cycle N can be consumed at cycle N+1 at the earliest. There is no same-cycle bypass.
- Final beat: an accepted beat is final if (beat_cnt+1 == E) or wdata_last_i.
  - On a non-final beat: beat_cnt increments.
  - On a final beat: the head is popped, beat_cnt returns to 0, and the done register loads {iid, err}.
  - err = len_err OR (wdata_last_i != (beat_cnt+1 == E)). This covers both an early WLAST and a missing WLAST.
  - done_valid_o is asserted in the cycle after the final beat (1-cycle latency).
- Done handshake:
  - done_valid_o holds, with iid and err stable, until done_valid_o && done_ready_i.
  - A new final beat may load the register in the same cycle the old token is taken. This gives back-to-back tokens with no bubble.
- Occupancy: occupancy_o = push - pop, updated each cycle.
  - Simultaneous push and pop leaves occupancy unchanged and is legal at any occupancy from 1 to Depth-1.
  - At occupancy Depth there is no push; at occupancy 0 there is no pop.
- Assertions (simulation only):
  - occupancy_o <= Depth.
  - No pop when empty.
  - done_iid_o stable while done_valid_o && !done_ready_i.

Test Plan:
- Reset, then push len=2 iid=1, then 3 beats with last only on the 3rd -> done_valid_o at the cycle after beat 3, done_iid_o=1, done_err_o=0; occupancy_o goes 1 then 0.
- Push len=3 iid=0, send WLAST on beat 2 -> burst ends after 2 beats; token iid=0, err=1; the next beat belongs to the next queued burst.
- Push len=7 iid=2 (exceeds MaxLenField) -> burst closes after 4 beats; err=1.
- Push 3 bursts (len 0,0,0; iid 0,1,2) while W idle -> waddr_ready_o=0 at occupancy 3. Then send 3 single-beat last beats with done_ready_i=1 -> tokens iid 0,1,2 on consecutive cycles; queue wraps; the 4th push is accepted.
- Hold done_ready_i=0 with a token pending and offer a beat -> wdata_ready_o=0 and the token stays stable. Release done_ready_i -> beat accepted the same cycle.
- Assert rst_i with 2 queued bursts and a pending token -> next cycle all outputs 0; no stale token after rst_i deasserts.

Source files
------------

// File: rtl/simmem_wbeat_tracker.sv
// simmem_wbeat_tracker: queues accepted write-address bursts and counts W
// beats against each burst's effective length, emitting one completion token
// {iid, err} per burst for the write-response bank.
module simmem_wbeat_tracker #(
  parameter int unsigned Depth       = 3,
  parameter int unsigned IidW        = 2,
  parameter int unsigned MaxLenField = 3,
  parameter int unsigned CntW        = 3,
  localparam int unsigned AxLenW     = 8,
  localparam int unsigned OccW       = $clog2(Depth + 1),
  localparam int unsigned PtrW       = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              waddr_valid_i,
  output logic              waddr_ready_o,
  input  logic [AxLenW-1:0] waddr_len_i,
  input  logic [IidW-1:0]   waddr_iid_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  input  logic              wdata_last_i,
  output logic              done_valid_o,
  input  logic              done_ready_i,
  output logic [IidW-1:0]   done_iid_o,
  output logic              done_err_o,
  output logic [OccW-1:0]   occupancy_o
);

  localparam logic [OccW-1:0]   DepthOcc  = OccW'(Depth);
  localparam logic [PtrW-1:0]   LastPtr   = PtrW'(Depth - 1);
  localparam logic [AxLenW-1:0] MaxLenAx  = AxLenW'(MaxLenField);
  localparam logic [CntW-1:0]   MaxLenCnt = CntW'(MaxLenField);

  logic [CntW-1:0] r_qlen [Depth];
  logic            r_qerr [Depth];
  logic [IidW-1:0] r_qiid [Depth];

  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [OccW-1:0] r_occ;
  logic [CntW-1:0] r_cnt;
  logic            r_done_valid;
  logic [IidW-1:0] r_done_iid;
  logic            r_done_err;

  logic            w_len_err;
  logic [CntW-1:0] w_len_clip;
  logic            w_push;
  logic            w_wacc;
  logic [CntW-1:0] w_eff;
  logic [CntW-1:0] w_cnt_inc;
  logic            w_hit;
  logic            w_final;
  logic            w_pop;
  logic            w_err;

  // Handshakes, length clipping and final-beat detection for the head burst
  always_comb begin
    w_len_err     = (waddr_len_i > MaxLenAx);
    w_len_clip    = w_len_err ? MaxLenCnt : CntW'(waddr_len_i);
    waddr_ready_o = !rst_i && (r_occ < DepthOcc);
    wdata_ready_o = !rst_i && (r_occ != '0) && (!r_done_valid || done_ready_i);
    w_push        = waddr_valid_i && waddr_ready_o;
    w_wacc        = wdata_valid_i && wdata_ready_o;
    w_eff         = r_qlen[r_rptr] + CntW'(1);
    w_cnt_inc     = r_cnt + CntW'(1);
    w_hit         = (w_cnt_inc == w_eff);
    w_final       = w_hit || wdata_last_i;
    w_pop         = w_wacc && w_final;
    w_err         = r_qerr[r_rptr] || (wdata_last_i != w_hit);
  end

  // Queue payload storage; contents are don't-care until pushed
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_qlen[r_wptr] <= w_len_clip;
      r_qerr[r_wptr] <= w_len_err;
      r_qiid[r_wptr] <= waddr_iid_i;
    end
  end

  // Queue pointers (wrap at Depth-1, no power-of-2 assumption) and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OccW'(1);
        2'b01:   r_occ <= r_occ - OccW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Beat counter for the burst at the head of the queue
  always_ff @(posedge clk_i) begin
    if (rst_i)       r_cnt <= '0;
    else if (w_wacc) r_cnt <= w_final ? '0 : w_cnt_inc;
  end

  // Completion token register; a reload in the take cycle gives bubble-free tokens
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_done_valid <= 1'b0;
      r_done_iid   <= '0;
      r_done_err   <= 1'b0;
    end else if (w_pop) begin
      r_done_valid <= 1'b1;
      r_done_iid   <= r_qiid[r_rptr];
      r_done_err   <= w_err;
    end else if (done_ready_i) begin
      r_done_valid <= 1'b0;
    end
  end

  assign done_valid_o = r_done_valid;
  assign done_iid_o   = r_done_iid;
  assign done_err_o   = r_done_err;
  assign occupancy_o  = r_occ;

`ifndef SYNTHESIS
  logic            r_chk_hold;
  logic [IidW-1:0] r_chk_iid;

  // Simulation checks: occupancy bound, no pop when empty, stalled token stable
  always_ff @(posedge clk_i) begin
    r_chk_hold <= !rst_i && r_done_valid && !done_ready_i;
    r_chk_iid  <= r_done_iid;
    assert (r_occ <= DepthOcc);
    assert (!(w_pop && (r_occ == '0)));
    if (r_chk_hold) assert (r_done_iid == r_chk_iid);
  end
`endif

endmodule
